kronos_mem_arb: RTL and testbench
=================================

KRONOS_MEM_ARB -- requirements
Module: kronos_mem_arb

Interface
REQ-001 Parameter: MEM_AW, default 10, word-address width of the memory port (bytes = 4*2^MEM_AW).
REQ-002 The block SHALL have the port clk, input, 1, sole clock.
REQ-003 The block SHALL have the port rstz, input, 1, reset (asynchronous, active-low).
REQ-004 The block SHALL have the port instr_addr, input, 32, core fetch byte address.
REQ-005 The block SHALL have the port instr_req, input, 1, fetch request, held until instr_gnt.
REQ-006 The block SHALL have the port instr_data, output, 32, fetch data, valid when instr_gnt=1.
REQ-007 The block SHALL have the port instr_gnt, output, 1, one-cycle fetch completion pulse.
REQ-008 The block SHALL have the ports data_addr (input, 32, byte address), data_wr_data (input, 32), data_wr_mask (input, 4, byte enables) and data_rd_data (output, 32, load data, valid when data_gnt=1).
REQ-009 The block SHALL have the ports data_rd_req (input, 1, load request) and data_wr_req (input, 1, store request), each held until data_gnt.
REQ-010 The block SHALL have the port data_gnt, output, 1, one-cycle load/store completion pulse.
REQ-011 The block SHALL have the ports mem_addr (output, MEM_AW, word address = addr[MEM_AW+1:2]), mem_wdata (output, 32), mem_wmask (output, 4), mem_ren (output, 1), mem_wen (output, 1) and mem_rdata (input, 32, synchronous-SRAM read data, valid one cycle after mem_ren).

Function
REQ-012 The FSM SHALL have the states IDLE and RESP, plus a registered owner field {INSTR, DATA_RD, DATA_WR}.
REQ-013 IDLE with any request: the block SHALL select a winner, drive mem_addr/mem_ren or mem_wen combinationally in the same cycle, latch the owner, and go to RESP.
REQ-014 RESP: the block SHALL pulse the owner's gnt for exactly 1 cycle; for reads, mem_rdata SHALL pass to the owner's data output; then go to IDLE. No memory access is issued in RESP.
REQ-015 Latency SHALL be request-to-gnt = 1 cycle (gnt in the cycle after issue); peak throughput SHALL be 1 access per 2 cycles.
REQ-016 mem_ren and mem_wen SHALL be mutually exclusive; mem_wdata/mem_wmask SHALL equal data_wr_data/data_wr_mask when mem_wen=1.
REQ-017 Within the data port, data_wr_req SHALL win over data_rd_req if both are asserted (illegal core usage; flagged by a simulation assertion).
REQ-018 A requester not selected SHALL see gnt=0 and SHALL win in a later IDLE cycle; requests are not queued internally.
REQ-019 The non-owner gnt SHALL be 0 in every cycle; instr_gnt and data_gnt SHALL never be high together.
REQ-020 Read data outputs SHALL be don't-care when their gnt=0; the bench checks them only on gnt.

Reset
REQ-021 rstz low SHALL immediately force state IDLE, owner INSTR, instr_gnt=0, data_gnt=0, mem_ren=0, mem_wen=0, and the RR pointer to "data next".
REQ-022 Reset in RESP SHALL abandon the access with no gnt; the first post-reset access SHALL start no earlier than the first rising edge with rstz high.

Configuration
REQ-023 Macro KRONOS_MEM_ARB_RR_EN: when defined, contention between instr and data SHALL alternate round-robin (pointer toggles after each contended grant). When undefined, data SHALL always win over instr (fixed priority).

Verification
REQ-024 Single fetch: instr_req=1, instr_addr=0x100, memory word 0x40=0x00000013 -> mem_ren=1 and mem_addr=0x40 in cycle 0, then instr_gnt=1 and instr_data=0x00000013 in cycle 1.
REQ-025 Store then load: write 0xDEADBEEF to 0x8 with mask 4'b0011, then read 0x8 with prior contents 0 -> data_rd_data=0x0000BEEF; each operation completes with a single data_gnt.
REQ-026 Contention without the macro: instr_req and data_rd_req held high for 8 cycles -> data_gnt on cycles 1, 3, 5, 7 and no instr_gnt; instr_gnt follows once data_rd_req drops.
REQ-027 Contention with KRONOS_MEM_ARB_RR_EN: same stimulus -> gnts alternate data, instr, data, instr.
REQ-028 Reset mid-access: rstz deasserted in the RESP cycle of a fetch -> no instr_gnt, mem_ren=0 during reset, and a clean fetch after release returns correct data.
REQ-029 Simultaneous data_rd_req and data_wr_req -> write performed (mem_wen=1, mem_ren=0) and the assertion fires.

Source files
------------

// File: rtl/kronos_mem_arb_if.sv
// Bundle of core-side (fetch, load/store) and SRAM-side signals for kronos_mem_arb.
// slave: the arbiter's view; master: the core + memory environment's view.
interface kronos_mem_arb_if #(
  parameter int MEM_AW = 10
);
  logic [31:0]       instr_addr;
  logic              instr_req;
  logic [31:0]       instr_data;
  logic              instr_gnt;

  logic [31:0]       data_addr;
  logic [31:0]       data_wr_data;
  logic [3:0]        data_wr_mask;
  logic [31:0]       data_rd_data;
  logic              data_rd_req;
  logic              data_wr_req;
  logic              data_gnt;

  logic [MEM_AW-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic [3:0]        mem_wmask;
  logic              mem_ren;
  logic              mem_wen;
  logic [31:0]       mem_rdata;

  modport slave (
    input  instr_addr, instr_req,
    output instr_data, instr_gnt,
    input  data_addr, data_wr_data, data_wr_mask, data_rd_req, data_wr_req,
    output data_rd_data, data_gnt,
    output mem_addr, mem_wdata, mem_wmask, mem_ren, mem_wen,
    input  mem_rdata
  );

  modport master (
    output instr_addr, instr_req,
    input  instr_data, instr_gnt,
    output data_addr, data_wr_data, data_wr_mask, data_rd_req, data_wr_req,
    input  data_rd_data, data_gnt,
    input  mem_addr, mem_wdata, mem_wmask, mem_ren, mem_wen,
    output mem_rdata
  );
endinterface

// File: rtl/kronos_mem_arb.sv
// Two-state arbiter sharing one synchronous SRAM port between fetch and load/store.
// Optional KRONOS_MEM_ARB_RR_EN: round-robin between fetch and data instead of data priority.
//
// state | meaning
// IDLE  | accept a request, issue the SRAM access combinationally, latch owner
// RESP  | SRAM data is valid; pulse owner's gnt, no new access
module kronos_mem_arb #(
  parameter int MEM_AW = 10
) (
  input logic              clk,
  input logic              rstz,
  kronos_mem_arb_if.slave  bus
);

  typedef enum logic {
    ST_IDLE,
    ST_RESP
  } state_e;

  typedef enum logic [1:0] {
    OWN_INSTR,
    OWN_DATA_RD,
    OWN_DATA_WR
  } owner_e;

  state_e      state_q, state_d;
  owner_e      owner_q, owner_d;

  logic        data_req;
  logic        data_first;
  logic [31:0] addr_sel;
  logic        ren;
  logic        wen;

  assign data_req = bus.data_rd_req | bus.data_wr_req;

`ifdef KRONOS_MEM_ARB_RR_EN
  logic rr_data_next_q, rr_data_next_d;

  assign data_first = rr_data_next_q;

  always_comb begin
    rr_data_next_d = rr_data_next_q;
    if (state_q == ST_IDLE && rstz && bus.instr_req && data_req) begin
      rr_data_next_d = ~rr_data_next_q;
    end
  end

  always_ff @(posedge clk or negedge rstz) begin
    if (!rstz) begin
      rr_data_next_q <= 1'b1;
    end else begin
      rr_data_next_q <= rr_data_next_d;
    end
  end
`else
  assign data_first = 1'b1;
`endif

  // Issue is gated by rstz so nothing reaches the SRAM while reset is held.
  always_comb begin
    state_d  = state_q;
    owner_d  = owner_q;
    addr_sel = bus.instr_addr;
    ren      = 1'b0;
    wen      = 1'b0;
    if (state_q == ST_IDLE) begin
      if (rstz && data_req && (!bus.instr_req || data_first)) begin
        addr_sel = bus.data_addr;
        state_d  = ST_RESP;
        if (bus.data_wr_req) begin
          owner_d = OWN_DATA_WR;
          wen     = 1'b1;
        end else begin
          owner_d = OWN_DATA_RD;
          ren     = 1'b1;
        end
      end else if (rstz && bus.instr_req) begin
        addr_sel = bus.instr_addr;
        owner_d  = OWN_INSTR;
        ren      = 1'b1;
        state_d  = ST_RESP;
      end
    end else begin
      state_d = ST_IDLE;
    end
  end

  always_ff @(posedge clk or negedge rstz) begin
    if (!rstz) begin
      state_q <= ST_IDLE;
      owner_q <= OWN_INSTR;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
    end
  end

  assign bus.mem_addr     = addr_sel[MEM_AW+1:2];
  assign bus.mem_ren      = ren;
  assign bus.mem_wen      = wen;
  assign bus.mem_wdata    = bus.data_wr_data;
  assign bus.mem_wmask    = bus.data_wr_mask;

  assign bus.instr_gnt    = (state_q == ST_RESP) && (owner_q == OWN_INSTR);
  assign bus.data_gnt     = (state_q == ST_RESP) && (owner_q != OWN_INSTR);
  assign bus.instr_data   = bus.mem_rdata;
  assign bus.data_rd_data = bus.mem_rdata;

  logic unused_addr_bits;
  assign unused_addr_bits = ^{addr_sel[31:MEM_AW+2], addr_sel[1:0]};

`ifndef SYNTHESIS
  // A core must never load and store at once; the store is taken and this is reported.
  always @(posedge clk) begin
    if (rstz && state_q == ST_IDLE) begin
      assert (!(bus.data_rd_req && bus.data_wr_req))
      else $warning("kronos_mem_arb: data_rd_req and data_wr_req both high, store taken");
    end
  end
`endif

endmodule

// File: tb/tb_kronos_mem_arb.sv
// Directed bench for kronos_mem_arb with a behavioural synchronous SRAM.
// Define KRONOS_MEM_ARB_RR_EN for both RTL and bench to check round-robin contention.
module tb_kronos_mem_arb;

  logic clk = 1'b0;
  logic rstz;
  int   total = 0;
  int   passed = 0;

  kronos_mem_arb_if #(.MEM_AW(10)) bus ();

  kronos_mem_arb #(.MEM_AW(10)) dut (
    .clk  (clk),
    .rstz (rstz),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  logic [31:0] sram [0:1023];

  always @(posedge clk) begin
    if (bus.mem_wen) begin
      for (int b = 0; b < 4; b++) begin
        if (bus.mem_wmask[b]) sram[bus.mem_addr][8*b +: 8] <= bus.mem_wdata[8*b +: 8];
      end
    end
    if (bus.mem_ren) bus.mem_rdata <= sram[bus.mem_addr];
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) $display("FAIL %s: got %h expected %h", tag, obs, exp);
    else passed++;
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  logic exp_dg, exp_ig;

  initial begin
    for (int i = 0; i < 1024; i++) sram[i] = 32'h0;
    sram[10'h040] = 32'h0000_0013;
    sram[10'h008] = 32'hA5A5_0008;
    sram[10'h050] = 32'hCAFE_F00D;
    bus.mem_rdata    = 32'h0;
    bus.instr_addr   = 32'h100;
    bus.instr_req    = 1'b1;
    bus.data_addr    = 32'h0;
    bus.data_wr_data = 32'h0;
    bus.data_wr_mask = 4'h0;
    bus.data_rd_req  = 1'b0;
    bus.data_wr_req  = 1'b0;
    rstz = 1'b0;

    // Reset state with a fetch already pending
    repeat (2) @(negedge clk);
    chk("rst_instr_gnt", bus.instr_gnt, 1'b0);
    chk("rst_data_gnt",  bus.data_gnt,  1'b0);
    chk("rst_mem_ren",   bus.mem_ren,   1'b0);
    chk("rst_mem_wen",   bus.mem_wen,   1'b0);
    bus.instr_req = 1'b0;
    cyc();
    rstz = 1'b1;
    cyc();

    // Single fetch
    bus.instr_addr = 32'h100;
    bus.instr_req  = 1'b1;
    @(negedge clk);
    chk("fetch_ren",  bus.mem_ren,  1'b1);
    chk("fetch_wen",  bus.mem_wen,  1'b0);
    chk("fetch_addr", bus.mem_addr, 32'h40);
    chk("fetch_gnt0", bus.instr_gnt, 1'b0);
    cyc();
    @(negedge clk);
    chk("fetch_gnt1", bus.instr_gnt, 1'b1);
    chk("fetch_data", bus.instr_data, 32'h0000_0013);
    chk("fetch_dgnt", bus.data_gnt, 1'b0);
    chk("fetch_resp_ren", bus.mem_ren, 1'b0);
    cyc();
    bus.instr_req = 1'b0;
    @(negedge clk);
    chk("fetch_gnt2", bus.instr_gnt, 1'b0);
    chk("fetch_idle_ren", bus.mem_ren, 1'b0);

    // Masked store then load
    cyc();
    bus.data_addr    = 32'h8;
    bus.data_wr_data = 32'hDEAD_BEEF;
    bus.data_wr_mask = 4'b0011;
    bus.data_wr_req  = 1'b1;
    @(negedge clk);
    chk("st_wen",   bus.mem_wen,   1'b1);
    chk("st_ren",   bus.mem_ren,   1'b0);
    chk("st_addr",  bus.mem_addr,  32'h2);
    chk("st_wdata", bus.mem_wdata, 32'hDEAD_BEEF);
    chk("st_wmask", bus.mem_wmask, 32'h3);
    cyc();
    @(negedge clk);
    chk("st_gnt",   bus.data_gnt,  1'b1);
    chk("st_igafter", bus.instr_gnt, 1'b0);
    cyc();
    bus.data_wr_req = 1'b0;
    bus.data_rd_req = 1'b1;
    @(negedge clk);
    chk("ld_ren",  bus.mem_ren,  1'b1);
    chk("ld_wen",  bus.mem_wen,  1'b0);
    chk("ld_gnt0", bus.data_gnt, 1'b0);
    cyc();
    @(negedge clk);
    chk("ld_gnt1", bus.data_gnt, 1'b1);
    chk("ld_data", bus.data_rd_data, 32'h0000_BEEF);
    cyc();
    bus.data_rd_req = 1'b0;
    @(negedge clk);
    chk("ld_gnt2", bus.data_gnt, 1'b0);

    // Fetch and load contending for 8 cycles
    cyc();
    bus.instr_addr  = 32'h100;
    bus.instr_req   = 1'b1;
    bus.data_addr   = 32'h20;
    bus.data_rd_req = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
`ifdef KRONOS_MEM_ARB_RR_EN
      exp_dg = (i == 1) || (i == 5);
      exp_ig = (i == 3) || (i == 7);
`else
      exp_dg = (i % 2) == 1;
      exp_ig = 1'b0;
`endif
      chk($sformatf("cont_dgnt_c%0d", i), bus.data_gnt, exp_dg);
      chk($sformatf("cont_ignt_c%0d", i), bus.instr_gnt, exp_ig);
      chk($sformatf("cont_rw_excl_c%0d", i), bus.mem_ren & bus.mem_wen, 1'b0);
      if (exp_dg) chk("cont_ddata", bus.data_rd_data, 32'hA5A5_0008);
      if (exp_ig) chk("cont_idata", bus.instr_data, 32'h0000_0013);
      if (i < 7) cyc();
    end
    cyc();
    bus.data_rd_req = 1'b0;
    @(negedge clk);
    chk("cont_tail_ren",  bus.mem_ren,  1'b1);
    chk("cont_tail_addr", bus.mem_addr, 32'h40);
    cyc();
    @(negedge clk);
    chk("cont_tail_ignt", bus.instr_gnt, 1'b1);
    chk("cont_tail_dgnt", bus.data_gnt,  1'b0);
    chk("cont_tail_data", bus.instr_data, 32'h0000_0013);
    cyc();
    bus.instr_req = 1'b0;

    // Reset during the response cycle of a fetch
    cyc();
    bus.instr_addr = 32'h140;
    bus.instr_req  = 1'b1;
    @(negedge clk);
    chk("rmid_ren", bus.mem_ren, 1'b1);
    chk("rmid_addr", bus.mem_addr, 32'h50);
    cyc();
    rstz = 1'b0;
    @(negedge clk);
    chk("rmid_ignt", bus.instr_gnt, 1'b0);
    chk("rmid_ren_rst", bus.mem_ren, 1'b0);
    cyc();
    @(negedge clk);
    chk("rmid_ignt2", bus.instr_gnt, 1'b0);
    chk("rmid_ren_rst2", bus.mem_ren, 1'b0);
    cyc();
    rstz = 1'b1;
    @(negedge clk);
    chk("rmid_reissue", bus.mem_ren, 1'b1);
    chk("rmid_igntx", bus.instr_gnt, 1'b0);
    cyc();
    @(negedge clk);
    chk("rmid_gnt", bus.instr_gnt, 1'b1);
    chk("rmid_data", bus.instr_data, 32'hCAFE_F00D);
    cyc();
    bus.instr_req = 1'b0;

    // Load and store asserted together: store is taken
    cyc();
    bus.data_addr    = 32'hC;
    bus.data_wr_data = 32'h1234_5678;
    bus.data_wr_mask = 4'hF;
    bus.data_rd_req  = 1'b1;
    bus.data_wr_req  = 1'b1;
    @(negedge clk);
    chk("both_wen",  bus.mem_wen,  1'b1);
    chk("both_ren",  bus.mem_ren,  1'b0);
    chk("both_addr", bus.mem_addr, 32'h3);
    cyc();
    @(negedge clk);
    chk("both_gnt", bus.data_gnt, 1'b1);
    cyc();
    bus.data_wr_req = 1'b0;
    @(negedge clk);
    chk("both_rd_ren", bus.mem_ren, 1'b1);
    cyc();
    @(negedge clk);
    chk("both_rd_gnt",  bus.data_gnt, 1'b1);
    chk("both_rd_data", bus.data_rd_data, 32'h1234_5678);
    cyc();
    bus.data_rd_req = 1'b0;
    @(negedge clk);
    chk("both_end_gnt", bus.data_gnt, 1'b0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
